// File: rtl/chan_mux_pkg.sv
// chan_mux_rr shared package: mode encodings, default sizes
// and the wrap-around channel index increment.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

  function automatic int wrap_inc(
    input int idx,
    input int n
  );
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, search from ptr up.
// Ports: req/ptr/en in; one-hot gnt, gnt_idx, any out.
module rr_arbiter
  import chan_mux_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  int k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    if (en) begin
      for (int i = 0; i < NCH; i++) begin
        k = (int'(ptr) + i) % NCH;
        if (!any && req[k]) begin
          any     = 1'b1;
          gnt[k]  = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: registered N-channel mux, fixed-select or round-robin.
// Ports: clk, rst_n (sync, active-low); in_data/in_valid/in_ready per
// channel; mode, sel; out_data/out_ch/out_valid/out_ready.
// MUX_PARITY_EN adds out_par, even parity of out_data.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
`ifdef MUX_PARITY_EN
  output logic                 out_par,
`endif
  input  logic                 out_ready
);

  logic            can_load;
  logic            sel_ok;
  logic            load;
  logic            rr_en;
  logic            rr_any;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] ld_idx;
  logic [NCH-1:0]  fix_gnt;
  logic [NCH-1:0]  rr_gnt;
  logic [NCH-1:0]  gnt;
  logic [WIDTH-1:0] ld_data;

  assign can_load = !out_valid || out_ready;
  assign rr_en    = rst_n && can_load && (mode == MODE_RR);

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .en      (rr_en),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // Fixed-mode ready ignores in_valid; out-of-range sel grants nothing.
  always_comb begin
    sel_ok  = int'(sel) < NCH;
    fix_gnt = '0;
    if (rst_n && can_load && sel_ok)
      fix_gnt[sel] = 1'b1;
  end

  always_comb begin
    gnt    = '0;
    ld_idx = '0;
    unique case (mode)
      MODE_FIXED: begin
        gnt    = fix_gnt;
        ld_idx = sel;
      end
      MODE_RR: begin
        gnt    = rr_gnt;
        ld_idx = rr_idx;
      end
      default: ;
    endcase
  end

  assign in_ready = gnt;
  assign load     = |(gnt & in_valid);
  assign ld_data  = in_data[int'(ld_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
`ifdef MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      if (load) begin
        out_data  <= ld_data;
        out_ch    <= ld_idx;
        out_valid <= 1'b1;
`ifdef MUX_PARITY_EN
        out_par   <= ^ld_data;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load && rr_any && mode == MODE_RR)
        rr_ptr <= SELW'(wrap_inc(int'(rr_idx), NCH));
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
// tb_chan_mux_rr: directed self-checking bench for chan_mux_rr,
// with a second NCH=3 instance for out-of-range select.
module tb_chan_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;

`ifdef MUX_PARITY_EN
  logic        out_par;
  logic        out_par3;
`endif

  int nchk;
  int nfail;

  chan_mux_rr #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef MUX_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

  chan_mux_rr #(.WIDTH(8), .NCH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
`ifdef MUX_PARITY_EN
    .out_par   (out_par3),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string       tag,
    input logic        v,
    input logic [7:0]  d,
    input logic [1:0]  c
  );
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    nchk      = 0;
    nfail     = 0;
    rst_n     = 1'b0;
    in_data   = 32'h40302010;
    in_valid  = 4'hF;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data3  = 24'h332211;
    in_valid3 = 3'b000;
    sel3      = 2'd0;

    // 1. reset, then fixed select of ch2
    tick();
    tick();
    chk("rst.ready", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.valid3", 32'(out_valid3), 32'h0);
    rst_n   = 1'b1;
    sel     = 2'd2;
    in_data = 32'h40A52010;
    #1;
    chk("fix.ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("fix.load", 1'b1, 8'hA5, 2'd2);
    in_valid = 4'h0;
    #1;
    chk("fix.ready_nov", 32'(in_ready), 32'h4);
    tick();
    chk("fix.drain", 32'(out_valid), 32'h0);

    // 2. round-robin fairness
    mode     = 1'b1;
    in_data  = 32'h40302010;
    in_valid = 4'hF;
    #1;
    chk("rr.ready0", 32'(in_ready), 32'h1);
    tick();
    chk_out("rr.0", 1'b1, 8'h10, 2'd0);
    chk("rr.ready1", 32'(in_ready), 32'h2);
    tick();
    chk_out("rr.1", 1'b1, 8'h20, 2'd1);
    tick();
    chk_out("rr.2", 1'b1, 8'h30, 2'd2);
    tick();
    chk_out("rr.3", 1'b1, 8'h40, 2'd3);
    tick();
    chk_out("rr.4", 1'b1, 8'h10, 2'd0);

    // 3. skip and wrap (ptr=1 -> ch2 brings ptr to 3)
    in_valid = 4'b0100;
    tick();
    chk_out("skip.ch2", 1'b1, 8'h30, 2'd2);
    in_valid = 4'b0010;
    #1;
    chk("wrap.ready1", 32'(in_ready), 32'h2);
    tick();
    chk_out("wrap.ch1", 1'b1, 8'h20, 2'd1);
    in_valid = 4'b1001;
    #1;
    chk("wrap.ready3", 32'(in_ready), 32'h8);
    tick();
    chk_out("wrap.ch3", 1'b1, 8'h40, 2'd3);
    chk("wrap.ready0", 32'(in_ready), 32'h1);
    tick();
    chk_out("wrap.ch0", 1'b1, 8'h10, 2'd0);

    // 4. backpressure, then drain+load with no bubble
    out_ready = 1'b0;
    in_valid  = 4'hF;
    #1;
    chk("bp.ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 8'h10, 2'd0);
      chk("bp.ready_h", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", 32'(in_ready), 32'h2);
    tick();
    chk_out("bp.nobubble", 1'b1, 8'h20, 2'd1);

    // 5. select limits
    mode      = 1'b0;
    sel       = 2'd3;
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    #1;
    chk("sel3.ready", 32'(in_ready), 32'h8);
    chk("nch3.ready", 32'(in_ready3), 32'h0);
    tick();
    chk_out("sel3.load", 1'b1, 8'h40, 2'd3);
    chk("nch3.valid", 32'(out_valid3), 32'h0);
    sel3 = 2'd1;
    #1;
    chk("nch3.ready1", 32'(in_ready3), 32'h2);
    tick();
    chk("nch3.data", 32'(out_data3), 32'h22);
    chk("nch3.ch", 32'(out_ch3), 32'h1);

    // 6. reset while holding
    sel     = 2'd0;
    in_data = 32'h4030205A;
    tick();
    chk_out("hold.load", 1'b1, 8'h5A, 2'd0);
    out_ready = 1'b0;
    tick();
    chk_out("hold.held", 1'b1, 8'h5A, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst.ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("mrst", 1'b0, 8'h00, 2'd0);
    rst_n     = 1'b1;
    mode      = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mrst.ptr", 32'(in_ready), 32'h1);

`ifdef MUX_PARITY_EN
    mode    = 1'b0;
    sel     = 2'd0;
    in_data = 32'h40302007;
    tick();
    chk("par.one", 32'(out_par), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("par.rst", 32'(out_par), 32'h0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/chan_mux_rr.md
Name: chan_mux_rr

Overview:
Parametrised, registered N-channel, W-bit multiplexer. Successor to the single-bit 2:1 select cell used across the Booth multiplier datapath.
- Each input channel has a valid/ready handshake.
- Two grant modes: fixed select, or round-robin arbitration.
- A single output register stage drives the downstream partial-product / accumulator path with output backpressure.

Parameters:
WIDTH, 8, data width per channel
NCH, 4, number of input channels (2..16)
SELW, $clog2(NCH), select/channel-index width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel data valid
in_ready  output  NCH  per-channel accept (combinational)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel selected in fixed mode
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  index of channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0; all in_ready=0 while rst_n=0. Reset mid-transfer discards held data.
- Handshake:
  - Transfer on input k when in_valid[k] && in_ready[k] at a clk edge.
  - Output transfer when out_valid && out_ready.
- can_load = !out_valid || out_ready (a drain and a load may occur in the same cycle; no bubble).
- At most one in_ready bit is high per cycle, and only when can_load=1.
- Latency: accepted data appears on out_data with out_valid=1 one cycle later.
- Hold: while out_valid && !out_ready, out_data and out_ch are stable.
- Fixed mode (mode=0):
  - in_ready[sel] = can_load.
  - Other channels get in_ready=0.
  - sel >= NCH: no grant.
  - rr_ptr is unchanged.
- Round-robin mode (mode=1):
  - Grant the first valid channel searching from rr_ptr upward, wrapping NCH-1 -> 0.
  - After an accepted transfer from k, rr_ptr = (k+1) mod NCH.
  - No accept: rr_ptr holds.
- in_ready is independent of in_valid in fixed mode. In RR mode, in_ready is asserted only for the granted valid channel.
- mode/sel changes take effect on the same cycle's grant. They never alter an already-held output.
- out_valid falls after a drain with no new load.
- Empty: no valid inputs -> no load. Full with no drain -> all in_ready=0.

Optional Feature:
Macro MUX_PARITY_EN.
- Defined: adds output port out_par (1 bit), the even parity (XOR reduction) of out_data.
  - Registered together with out_data; reset value 0.
  - Held with out_data under backpressure.
- Undefined: port absent; no parity logic.

Decomposition:
- Package chan_mux_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Default WIDTH/NCH localparams.
  - Function for the wrap-around index increment.
- Sub-module rr_arbiter (purely combinational):
  - Inputs: req[NCH], ptr[SELW], en.
  - Outputs: one-hot gnt[NCH], gnt_idx[SELW], any.
- Top-level holds the rr_ptr register, output register and handshake logic.

Test Plan:
1. Reset, fixed mode: rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0. Then mode=0, sel=2, in_data ch2=0xA5, out_ready=1 -> next cycle out_data=0xA5, out_ch=2, only in_ready[2]=1.
2. Round-robin fairness: mode=1, all four valid (0x10,0x20,0x30,0x40), out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with matching data.
3. RR skip and wrap: rr_ptr=3, only ch1 valid -> grant ch1, next rr_ptr=2. Then only ch3 and ch0 valid -> grant ch3, then ch0.
4. Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data/out_ch frozen, in_ready=0000. Raising out_ready -> drain and new load in the same cycle, no bubble.
5. Invalid select: mode=0, NCH=4 with sel=3 valid; NCH=3 build with sel=3 -> no grant, out_valid stays 0.
6. Reset mid-hold: out_valid=1 with 0x5A held, rst_n=0 for 1 cycle -> out_valid=0, out_data=0, rr_ptr=0. With MUX_PARITY_EN, out_data=0x07 -> out_par=1, reset -> out_par=0.
